// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo/saturating up-down counter with step, overflow/underflow pulses and sticky flags
module mod_updown_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_value_i,
  input  logic              dir_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  limit_i,
  input  logic              sat_mode_i,
  input  logic              clr_flags_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              ovf_pulse_o,
  output logic              unf_pulse_o,
  output logic              ovf_sticky_o,
  output logic              unf_sticky_o,
  output logic              at_limit_o,
  output logic              at_zero_o
);
  localparam int unsigned W1 = WIDTH + 1;
  logic [WIDTH-1:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, ovf_sticky_q, ovf_sticky_d, unf_sticky_q, unf_sticky_d;
  logic [W1-1:0] lim_x, lim1, stp, s, cnt, sum, diff, wrap_dn;
  logic oor;
  always_comb begin
    lim_x = {1'b0, limit_i};
    lim1 = lim_x + W1'(1);
    stp = W1'(step_i);
    s = stp > lim1 ? lim1 : stp;
    cnt = {1'b0, count_q};
    sum = cnt + s;
    diff = cnt - s;
    wrap_dn = cnt + lim1 - s;
    oor = count_q > limit_i;
    count_d = count_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load_i) begin
      count_d = load_value_i > limit_i ? limit_i : load_value_i;
    end else if (enable_i && s != '0) begin
      // A count left above a lowered limit is pulled back into range as an overflow.
      if (oor) begin
        count_d = sat_mode_i ? limit_i : '0;
        ovf_d = 1'b1;
      end else if (!dir_i) begin
        if (sum <= lim_x) begin
          count_d = WIDTH'(sum);
        end else begin
          count_d = sat_mode_i ? limit_i : WIDTH'(sum - lim1);
          ovf_d = 1'b1;
        end
      end else if (cnt >= s) begin
        count_d = WIDTH'(diff);
      end else begin
        count_d = sat_mode_i ? '0 : WIDTH'(wrap_dn);
        unf_d = 1'b1;
      end
    end
    ovf_sticky_d = ovf_d | (ovf_sticky_q & ~clr_flags_i);
    unf_sticky_d = unf_d | (unf_sticky_q & ~clr_flags_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end
  assign count_o = count_q;
  assign ovf_pulse_o = ovf_q;
  assign unf_pulse_o = unf_q;
  assign ovf_sticky_o = ovf_sticky_q;
  assign unf_sticky_o = unf_sticky_q;
  assign at_limit_o = count_q == limit_i;
  assign at_zero_o = count_q == '0;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed vector table plus reset sequences for mod_updown_counter
module tb_mod_updown_counter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic enable = 1'b0, load = 1'b0, dir = 1'b0, sat_mode = 1'b0, clr_flags = 1'b0;
  logic [7:0] load_value = '0, limit = 8'd255;
  logic [3:0] step = 4'd1;
  logic [7:0] count;
  logic ovf_pulse, unf_pulse, ovf_sticky, unf_sticky, at_limit, at_zero;
  int tests = 0, fails = 0;
  typedef struct {
    logic ld; logic [7:0] lv; logic en; logic dr; logic [3:0] st; logic [7:0] lim; logic sm; logic clr;
    logic [7:0] c; logic op; logic up; logic os; logic us;
  } vec_t;
  vec_t vt[26];
  mod_updown_counter #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .load_i(load), .load_value_i(load_value),
    .dir_i(dir), .step_i(step), .limit_i(limit), .sat_mode_i(sat_mode), .clr_flags_i(clr_flags),
    .count_o(count), .ovf_pulse_o(ovf_pulse), .unf_pulse_o(unf_pulse), .ovf_sticky_o(ovf_sticky),
    .unf_sticky_o(unf_sticky), .at_limit_o(at_limit), .at_zero_o(at_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [7:0] c, input logic op, input logic up,
                           input logic os, input logic us, input logic [7:0] lim);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " ovf_pulse"}, 32'(ovf_pulse), 32'(op));
    chk({tag, " unf_pulse"}, 32'(unf_pulse), 32'(up));
    chk({tag, " ovf_sticky"}, 32'(ovf_sticky), 32'(os));
    chk({tag, " unf_sticky"}, 32'(unf_sticky), 32'(us));
    chk({tag, " at_limit"}, 32'(at_limit), 32'(c == lim));
    chk({tag, " at_zero"}, 32'(at_zero), 32'(c == 8'd0));
  endtask
  task automatic step_edge(input logic ld, input logic [7:0] lv, input logic en, input logic dr,
                           input logic [3:0] st, input logic [7:0] lim, input logic sm, input logic clr);
    @(negedge clk);
    load = ld; load_value = lv; enable = en; dir = dr; step = st; limit = lim; sat_mode = sm; clr_flags = clr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // ld lv en dr st lim sm clr | count ovfp unfp ovfs unfs
    vt[0]  = '{1, 42,  0, 0, 1,  255, 0, 0,  42, 0, 0, 0, 0};
    vt[1]  = '{0, 0,   0, 0, 1,  255, 0, 0,  42, 0, 0, 0, 0};
    vt[2]  = '{1, 100, 1, 0, 1,  255, 0, 0, 100, 0, 0, 0, 0};
    vt[3]  = '{0, 0,   1, 0, 1,  255, 0, 0, 101, 0, 0, 0, 0};
    vt[4]  = '{1, 7,   0, 0, 3,  9,   0, 0,   7, 0, 0, 0, 0};
    vt[5]  = '{0, 0,   1, 0, 3,  9,   0, 0,   0, 1, 0, 1, 0};
    vt[6]  = '{0, 0,   1, 0, 3,  9,   0, 0,   3, 0, 0, 1, 0};
    vt[7]  = '{0, 0,   1, 0, 3,  9,   0, 0,   6, 0, 0, 1, 0};
    vt[8]  = '{0, 0,   1, 0, 3,  9,   0, 0,   9, 0, 0, 1, 0};
    vt[9]  = '{0, 0,   1, 0, 3,  9,   0, 0,   2, 1, 0, 1, 0};
    vt[10] = '{1, 2,   0, 1, 4,  9,   0, 1,   2, 0, 0, 0, 0};
    vt[11] = '{0, 0,   1, 1, 4,  9,   0, 0,   8, 0, 1, 0, 1};
    vt[12] = '{0, 0,   1, 1, 4,  9,   0, 0,   4, 0, 0, 0, 1};
    vt[13] = '{0, 0,   1, 1, 4,  9,   0, 0,   0, 0, 0, 0, 1};
    vt[14] = '{0, 0,   1, 1, 4,  9,   0, 0,   6, 0, 1, 0, 1};
    vt[15] = '{1, 250, 0, 0, 15, 255, 1, 1, 250, 0, 0, 0, 0};
    vt[16] = '{0, 0,   1, 0, 15, 255, 1, 0, 255, 1, 0, 1, 0};
    vt[17] = '{0, 0,   1, 0, 15, 255, 1, 0, 255, 1, 0, 1, 0};
    vt[18] = '{1, 5,   0, 1, 15, 255, 1, 0,   5, 0, 0, 1, 0};
    vt[19] = '{0, 0,   1, 1, 15, 255, 1, 0,   0, 0, 1, 1, 1};
    vt[20] = '{0, 0,   1, 1, 15, 255, 1, 0,   0, 0, 1, 1, 1};
    vt[21] = '{1, 200, 0, 0, 1,  99,  0, 1,  99, 0, 0, 0, 0};
    vt[22] = '{0, 0,   1, 0, 1,  50,  0, 0,   0, 1, 0, 1, 0};
    vt[23] = '{0, 0,   1, 0, 1,  0,   0, 1,   0, 1, 0, 1, 0};
    vt[24] = '{0, 0,   0, 0, 1,  0,   0, 1,   0, 0, 0, 0, 0};
    vt[25] = '{0, 0,   1, 0, 0,  9,   0, 0,   0, 0, 0, 0, 0};
    #2;
    check_all("reset", 8'd0, 0, 0, 0, 0, 8'd255);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      step_edge(vt[i].ld, vt[i].lv, vt[i].en, vt[i].dr, vt[i].st, vt[i].lim, vt[i].sm, vt[i].clr);
      check_all($sformatf("vec%0d", i), vt[i].c, vt[i].op, vt[i].up, vt[i].os, vt[i].us, vt[i].lim);
    end
    step_edge(1, 255, 0, 0, 1, 255, 0, 0);
    check_all("pre_ovf", 8'd255, 0, 0, 0, 0, 8'd255);
    step_edge(0, 0, 1, 0, 1, 255, 0, 0);
    check_all("ovf_wrap", 8'd0, 1, 0, 1, 0, 8'd255);
    step_edge(1, 72, 0, 0, 1, 255, 0, 0);
    step_edge(0, 0, 1, 0, 1, 255, 0, 0);
    check_all("mid_count", 8'd73, 0, 0, 1, 0, 8'd255);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 8'd0, 0, 0, 0, 0, 8'd255);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1 check_all("post_rst", 8'd1, 0, 0, 0, 0, 8'd255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised successor to the 8-bit `counter`. It adds a programmable modulus (`limit`), up/down direction, a configurable step, and a choice of wrap or saturate at the boundaries. It also provides registered overflow/underflow event pulses, sticky flags with clear, and boundary indicators. It serves as the general-purpose event/timer counter in the same verification environment, with the same `enable`/`load` semantics as `counter`.

## Interface
- WIDTH, 8, count/limit/load width; legal 2..32
- STEP_W, 4, step width; legal 1..WIDTH
- RESET_VAL, 0, count value after reset; must be ≤ 2^WIDTH-1

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  advance count by one step per cycle
- load  in  1  synchronous load, priority over enable
- load_value  in  WIDTH  value loaded when load=1
- dir  in  1  0 = count up, 1 = count down
- step  in  STEP_W  increment/decrement magnitude
- limit  in  WIDTH  terminal value; count range is 0..limit
- sat_mode  in  1  0 = wrap modulo limit+1, 1 = saturate at 0/limit
- clr_flags  in  1  clear sticky flags
- count  out  WIDTH  current count (registered)
- ovf_pulse  out  1  one-cycle pulse: last update crossed/hit upper bound
- unf_pulse  out  1  one-cycle pulse: last update crossed lower bound
- ovf_sticky  out  1  sticky overflow
- unf_sticky  out  1  sticky underflow
- at_limit  out  1  combinational: count == limit
- at_zero  out  1  combinational: count == 0

## Operation
- Priority at each rising edge: rst_n low > load > enable > hold.
- Load: count ← min(load_value, limit). No pulses are generated.
- Effective step: s = min(step, limit+1). All arithmetic uses WIDTH+1 bits; there is no silent truncation.
- step = 0 with enable: count holds and no pulses are generated.
- Enabled up (dir=0), with count ≤ limit:
  - If count + s ≤ limit: count ← count + s.
  - Otherwise, wrap mode: count ← count + s − (limit+1). Saturate mode: count ← limit. In both modes, ovf_pulse is asserted.
  - Saturate mode at count == limit: count stays at limit and ovf_pulse is asserted every enabled cycle.
- Enabled down (dir=1), with count ≤ limit:
  - If count ≥ s: count ← count − s.
  - Otherwise, wrap mode: count ← count + (limit+1) − s. Saturate mode: count ← 0. In both modes, unf_pulse is asserted.
  - Saturate mode at count == 0 with s > 0: unf_pulse is asserted every enabled cycle.
- Out-of-range count (limit lowered below count): the next enabled step, in either direction, sets count to 0 (wrap mode) or to limit (saturate mode) and asserts ovf_pulse. While disabled, count holds its out-of-range value.
- Sticky flags:
  - An ovf_pulse event sets ovf_sticky; an unf_pulse event sets unf_sticky.
  - clr_flags clears both stickies on the next edge.
  - An event in the same cycle as clr_flags wins: the sticky stays 1.
- dir, step, limit and sat_mode are sampled every edge. Changing them mid-count is legal and takes effect on the next enabled edge.

## Timing
- Reset (asynchronous, immediate):
  - count = RESET_VAL.
  - ovf_pulse, unf_pulse, ovf_sticky, unf_sticky = 0.
  - at_limit and at_zero follow count combinationally.
- Latency:
  - load, enable and step updates: count is valid 1 cycle after the sampling edge.
  - Pulses are registered and asserted in the same cycle as the new count value, for exactly 1 cycle.
  - Stickies rise in the same cycle as the pulse.
- Back-to-back load cycles: the last loaded value wins. Enabled counting resumes on the first edge with load=0.
- Reset release: the first active edge after rst_n rises may load or count. There is no extra idle cycle.
- at_limit and at_zero have zero latency from count. With limit = 0, both are high at count = 0.

## Test plan
- Reset/load (WIDTH=8, STEP_W=4):
  - Stimulus: load 42 with enable=0; then load 100 with enable=1, release load, one more edge.
  - Required: count = 42 and holds. Then count = 100, then 101. No pulses.
- Up wrap:
  - Stimulus: limit=9, step=3, sat_mode=0, load 7, enable up.
  - Required: count sequence 7→0→3→6→9→2. ovf_pulse is high in the cycles count shows 0 and 2. ovf_sticky = 1.
- Down wrap:
  - Stimulus: limit=9, step=4, load 2, dir=1, enable.
  - Required: 2→8→4→0→6. unf_pulse is high at 8 and at 6. unf_sticky = 1; ovf_sticky = 0.
- Saturate:
  - Stimulus: limit=255, step=15, sat_mode=1, load 250, up for 2 cycles; then load 5, down for 2 cycles.
  - Required: up gives 255, 255 with ovf_pulse high both cycles. Down gives 0, 0 with unf_pulse high both cycles.
- Range clamp:
  - Stimulus: limit=99, load_value 200; then limit=50 with count 99, one enabled up step, wrap mode.
  - Required: load gives count = 99. The step gives count = 0 with ovf_pulse asserted.
- Flags and async reset:
  - Stimulus: assert clr_flags in the same cycle as an overflow event; then assert clr_flags alone; then drop rst_n between clock edges mid-count (count = 73).
  - Required: ovf_sticky stays 1 after the combined cycle, then clears to 0. On rst_n low, count = 0 and all flags = 0 immediately, without waiting for a clock edge.
